// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types for the PPU background fetch scheduler.
// Holds the bg_type codes, the fetch-slot descriptor and the default line width.
package ppu_pkg;

  localparam int FETCH_DOTS_DEFAULT = 264;

  typedef enum logic [2:0] {
    BG_OPT     = 3'b000,
    BG_2BPP    = 3'b001,
    BG_4BPP    = 3'b010,
    BG_8BPP    = 3'b011,
    BG_OPT4    = 3'b100,
    BG_2BPP_HR = 3'b101,
    BG_4BPP_HR = 3'b110,
    BG_NONE    = 3'b111
  } bg_type_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DONE
  } sched_state_e;

  typedef struct packed {
    logic [1:0] bg;
    logic       is_map;
    logic       is_data;
    logic [2:0] num;
  } slot_t;

  localparam logic [1:0] B1 = 2'd0;
  localparam logic [1:0] B2 = 2'd1;
  localparam logic [1:0] B3 = 2'd2;
  localparam logic [1:0] B4 = 2'd3;

  localparam slot_t SLOT_IDLE = '0;

  function automatic slot_t map_s(
    input logic [1:0] b,
    input logic [2:0] n
  );
    slot_t s;
    s.bg      = b;
    s.is_map  = 1'b1;
    s.is_data = 1'b0;
    s.num     = n;
    return s;
  endfunction

  function automatic slot_t dat_s(
    input logic [1:0] b,
    input logic [2:0] n
  );
    slot_t s;
    s.bg      = b;
    s.is_map  = 1'b0;
    s.is_data = 1'b1;
    s.num     = n;
    return s;
  endfunction

endpackage

// File: rtl/bg_fetch_sched_if.sv
// bg_fetch_sched_if: line-control inputs and per-BG fetch outputs
// of the BG fetch scheduler; slave is the scheduler side.
interface bg_fetch_sched_if;
  logic        dot_en;
  logic        line_start;
  logic        line_active;
  logic [2:0]  bgmode;
  logic [3:0]  bg_enable;
  logic [3:0]  fetch_map;
  logic [3:0]  fetch_data;
  logic [2:0]  fetch_data_num;
  logic [8:0]  fetch_x;
  logic        newline;
  logic [11:0] bg_type;
  logic [1:0]  vram_sel;
  logic        busy;

  modport master (
    output dot_en, line_start, line_active,
    output bgmode, bg_enable,
    input  fetch_map, fetch_data, fetch_data_num,
    input  fetch_x, newline, bg_type,
    input  vram_sel, busy
  );

  modport slave (
    input  dot_en, line_start, line_active,
    input  bgmode, bg_enable,
    output fetch_map, fetch_data, fetch_data_num,
    output fetch_x, newline, bg_type,
    output vram_sel, busy
  );
endinterface

// File: rtl/bg_fetch_slot_rom.sv
// bg_fetch_slot_rom: (mode, slot) -> fetch slot and per-BG type codes.
// PPU_BG_OPT_EN enables the offset-per-tile slots of modes 2/4/6.
module bg_fetch_slot_rom
  import ppu_pkg::*;
(
  input  logic [2:0]  mode_i,
  input  logic [2:0]  slot_i,
  output slot_t       slot_o,
  output logic [11:0] bg_type_o
);

`ifdef PPU_BG_OPT_EN
  localparam logic OPT_EN = 1'b1;
`else
  localparam logic OPT_EN = 1'b0;
`endif

  bg_type_e t1, t2, t3, t4;

  always_comb begin
    slot_o = SLOT_IDLE;
    case (mode_i)
      3'd0: begin
        case (slot_i)
          3'd0: slot_o = map_s(B4, 3'd0);
          3'd1: slot_o = map_s(B3, 3'd0);
          3'd2: slot_o = map_s(B2, 3'd0);
          3'd3: slot_o = map_s(B1, 3'd0);
          3'd4: slot_o = dat_s(B4, 3'd0);
          3'd5: slot_o = dat_s(B3, 3'd0);
          3'd6: slot_o = dat_s(B2, 3'd0);
          3'd7: slot_o = dat_s(B1, 3'd0);
        endcase
      end
      3'd1, 3'd2: begin
        case (slot_i)
          3'd0: slot_o = map_s(B3, 3'd0);
          3'd1: slot_o = dat_s(B3, 3'd0);
          3'd2: slot_o = map_s(B2, 3'd0);
          3'd3: slot_o = dat_s(B2, 3'd0);
          3'd4: slot_o = dat_s(B2, 3'd2);
          3'd5: slot_o = map_s(B1, 3'd0);
          3'd6: slot_o = dat_s(B1, 3'd0);
          3'd7: slot_o = dat_s(B1, 3'd2);
        endcase
        // Mode 2 trades the BG3 tile fetch for the h/v offset pair
        if (mode_i == 3'd2 && slot_i == 3'd0)
          slot_o = OPT_EN ? map_s(B3, 3'd0) : SLOT_IDLE;
        if (mode_i == 3'd2 && slot_i == 3'd1)
          slot_o = OPT_EN ? map_s(B3, 3'd1) : SLOT_IDLE;
      end
      3'd3: begin
        case (slot_i)
          3'd0: slot_o = map_s(B2, 3'd0);
          3'd1: slot_o = dat_s(B2, 3'd0);
          3'd2: slot_o = dat_s(B2, 3'd2);
          3'd3: slot_o = map_s(B1, 3'd0);
          3'd4: slot_o = dat_s(B1, 3'd0);
          3'd5: slot_o = dat_s(B1, 3'd2);
          3'd6: slot_o = dat_s(B1, 3'd4);
          3'd7: slot_o = dat_s(B1, 3'd6);
        endcase
      end
      3'd4: begin
        case (slot_i)
          3'd0: slot_o = OPT_EN ? map_s(B3, 3'd0) : SLOT_IDLE;
          3'd1: slot_o = map_s(B2, 3'd0);
          3'd2: slot_o = dat_s(B2, 3'd0);
          3'd3: slot_o = map_s(B1, 3'd0);
          3'd4: slot_o = dat_s(B1, 3'd0);
          3'd5: slot_o = dat_s(B1, 3'd2);
          3'd6: slot_o = dat_s(B1, 3'd4);
          3'd7: slot_o = dat_s(B1, 3'd6);
        endcase
      end
      3'd5: begin
        case (slot_i)
          3'd0: slot_o = map_s(B2, 3'd0);
          3'd1: slot_o = dat_s(B2, 3'd0);
          3'd2: slot_o = dat_s(B2, 3'd1);
          3'd3: slot_o = map_s(B1, 3'd0);
          3'd4: slot_o = dat_s(B1, 3'd0);
          3'd5: slot_o = dat_s(B1, 3'd1);
          3'd6: slot_o = dat_s(B1, 3'd2);
          3'd7: slot_o = dat_s(B1, 3'd3);
        endcase
      end
      3'd6: begin
        case (slot_i)
          3'd0: slot_o = OPT_EN ? map_s(B3, 3'd0) : SLOT_IDLE;
          3'd1: slot_o = OPT_EN ? map_s(B3, 3'd1) : SLOT_IDLE;
          3'd3: slot_o = map_s(B1, 3'd0);
          3'd4: slot_o = dat_s(B1, 3'd0);
          3'd5: slot_o = dat_s(B1, 3'd1);
          3'd6: slot_o = dat_s(B1, 3'd2);
          3'd7: slot_o = dat_s(B1, 3'd3);
          default: slot_o = SLOT_IDLE;
        endcase
      end
      default: slot_o = SLOT_IDLE;
    endcase
  end

  always_comb begin
    t1 = BG_NONE;
    t2 = BG_NONE;
    t3 = BG_NONE;
    t4 = BG_NONE;
    case (mode_i)
      3'd0: begin
        t1 = BG_2BPP;
        t2 = BG_2BPP;
        t3 = BG_2BPP;
        t4 = BG_2BPP;
      end
      3'd1: begin
        t1 = BG_4BPP;
        t2 = BG_4BPP;
        t3 = BG_2BPP;
      end
      3'd2: begin
        t1 = BG_4BPP;
        t2 = BG_4BPP;
        t3 = OPT_EN ? BG_OPT : BG_NONE;
      end
      3'd3: begin
        t1 = BG_8BPP;
        t2 = BG_4BPP;
      end
      3'd4: begin
        t1 = BG_8BPP;
        t2 = BG_2BPP;
        t3 = OPT_EN ? BG_OPT4 : BG_NONE;
      end
      3'd5: begin
        t1 = BG_4BPP_HR;
        t2 = BG_2BPP_HR;
      end
      3'd6: begin
        t1 = BG_4BPP_HR;
        t3 = OPT_EN ? BG_OPT : BG_NONE;
      end
      default: ;
    endcase
  end

  assign bg_type_o = {t4, t3, t2, t1};

endmodule

// File: rtl/bg_fetch_sched.sv
// bg_fetch_sched: per-scanline VRAM fetch scheduler for the four BG units.
// Build option PPU_BG_OPT_EN (see bg_fetch_slot_rom) enables offset-per-tile slots.
module bg_fetch_sched
  import ppu_pkg::*;
#(
  parameter int FETCH_DOTS = FETCH_DOTS_DEFAULT
) (
  input logic             clk,
  input logic             reset,
  bg_fetch_sched_if.slave sched_if
);

  localparam logic [8:0] LAST_X = 9'(FETCH_DOTS - 1);

  sched_state_e state_q, state_d;
  logic [8:0]   x_q, x_d;
  logic [2:0]   mode_q, mode_d;
  logic [3:0]   en_q, en_d;
  logic         vld_q, vld_d;
  logic         nl_q, nl_d;

  slot_t        slot;
  logic [11:0]  type_raw;
  logic         busy;
  logic [3:0]   map_d, dat_d;
  logic [2:0]   num_d;
  logic [1:0]   sel_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      mode_q  <= '0;
      en_q    <= '0;
      vld_q   <= 1'b0;
      nl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      vld_q   <= vld_d;
      nl_q    <= nl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    mode_d  = mode_q;
    en_d    = en_q;
    vld_d   = vld_q;
    nl_d    = nl_q;
    if (sched_if.dot_en) begin
      nl_d = 1'b0;
      if (sched_if.line_start) begin
        x_d = '0;
        if (sched_if.line_active) begin
          state_d = S_FETCH;
          mode_d  = sched_if.bgmode;
          en_d    = sched_if.bg_enable;
          vld_d   = 1'b1;
          nl_d    = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end else begin
        case (state_q)
          S_FETCH: begin
            if (x_q == LAST_X) state_d = S_DONE;
            else x_d = x_q + 9'd1;
          end
          default: ;
        endcase
      end
    end
  end

  bg_fetch_slot_rom u_rom (
    .mode_i    (mode_q),
    .slot_i    (x_q[2:0]),
    .slot_o    (slot),
    .bg_type_o (type_raw)
  );

  assign busy = (state_q == S_FETCH);

  // Disabled BGs keep their slot; only the strobe is masked
  always_comb begin
    map_d = '0;
    dat_d = '0;
    num_d = '0;
    sel_d = '0;
    if (busy) begin
      sel_d = slot.bg;
      num_d = slot.num;
      if (slot.is_map)  map_d[slot.bg] = en_q[slot.bg];
      if (slot.is_data) dat_d[slot.bg] = en_q[slot.bg];
    end
  end

  assign sched_if.fetch_map      = map_d;
  assign sched_if.fetch_data     = dat_d;
  assign sched_if.fetch_data_num = num_d;
  assign sched_if.vram_sel       = sel_d;
  assign sched_if.fetch_x        = x_q;
  assign sched_if.newline        = nl_q;
  assign sched_if.busy           = busy;
  assign sched_if.bg_type        = vld_q ? type_raw : '1;

endmodule

// File: tb/tb_bg_fetch_sched.sv
// tb_bg_fetch_sched: directed self-checking bench for bg_fetch_sched.
// Expected values are hand-derived from the slot timetable.
module tb_bg_fetch_sched;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  bg_fetch_sched_if bus ();

  bg_fetch_sched #(.FETCH_DOTS(264)) dut (
    .clk      (clk),
    .reset    (reset),
    .sched_if (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input logic [2:0] m, input logic [3:0] en);
    bus.bgmode      = m;
    bus.bg_enable   = en;
    bus.line_active = 1'b1;
    bus.line_start  = 1'b1;
    bus.dot_en      = 1'b1;
    tick();
    bus.line_start  = 1'b0;
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    bus.dot_en      = 1'b0;
    bus.line_start  = 1'b0;
    bus.line_active = 1'b0;
    bus.bgmode      = 3'd0;
    bus.bg_enable   = 4'h0;
    #22;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    total++; if (bus.fetch_x !== 9'd0) begin bad++; $display("FAIL rst_x got=%0d exp=0", bus.fetch_x); end
    total++; if (bus.bg_type !== 12'hFFF) begin bad++; $display("FAIL rst_type got=%h exp=fff", bus.bg_type); end
    total++; if ({bus.fetch_map, bus.fetch_data, bus.fetch_data_num, bus.vram_sel, bus.newline} !== 14'd0)
      begin bad++; $display("FAIL rst_outs got=%h exp=0", {bus.fetch_map, bus.fetch_data, bus.fetch_data_num, bus.vram_sel, bus.newline}); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.dot_en = 1'b1;
    repeat (3) tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_idle got=%b exp=0", bus.busy); end
  endtask

  task automatic test_mode1();
    start_line(3'd1, 4'hF);
    total++; if (bus.fetch_map !== 4'b0100) begin bad++; $display("FAIL m1_map0 got=%b exp=0100", bus.fetch_map); end
    total++; if (bus.vram_sel !== 2'd2) begin bad++; $display("FAIL m1_sel0 got=%0d exp=2", bus.vram_sel); end
    total++; if (bus.newline !== 1'b1) begin bad++; $display("FAIL m1_nl_hi got=%b exp=1", bus.newline); end
    total++; if (bus.bg_type !== 12'hE52) begin bad++; $display("FAIL m1_type got=%h exp=e52", bus.bg_type); end
    tick();
    total++; if (bus.newline !== 1'b0) begin bad++; $display("FAIL m1_nl_lo got=%b exp=0", bus.newline); end
    total++; if (bus.fetch_data !== 4'b0100) begin bad++; $display("FAIL m1_dat1 got=%b exp=0100", bus.fetch_data); end
    repeat (6) tick();
    total++; if (bus.fetch_data !== 4'b0001) begin bad++; $display("FAIL m1_dat7 got=%b exp=0001", bus.fetch_data); end
    total++; if (bus.fetch_data_num !== 3'd2) begin bad++; $display("FAIL m1_num7 got=%0d exp=2", bus.fetch_data_num); end
    repeat (256) tick();
    total++; if (bus.fetch_x !== 9'd263 || bus.busy !== 1'b1)
      begin bad++; $display("FAIL m1_last got=%0d/%b exp=263/1", bus.fetch_x, bus.busy); end
    tick();
    total++; if (bus.busy !== 1'b0 || bus.fetch_x !== 9'd263)
      begin bad++; $display("FAIL m1_done got=%0d/%b exp=263/0", bus.fetch_x, bus.busy); end
    total++; if (bus.fetch_map !== 4'd0 || bus.fetch_data !== 4'd0)
      begin bad++; $display("FAIL m1_quiet got=%b/%b exp=0/0", bus.fetch_map, bus.fetch_data); end
  endtask

  task automatic test_enable_mask();
    int mc[4];
    int dc[4];
    int sel_err;
    int s;
    logic [1:0] exp_sel;
    for (int b = 0; b < 4; b++) begin mc[b] = 0; dc[b] = 0; end
    sel_err = 0;
    start_line(3'd0, 4'b0101);
    for (int d = 0; d < 264; d++) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.fetch_map[b]) mc[b]++;
        if (bus.fetch_data[b]) dc[b]++;
      end
      s = d % 8;
      exp_sel = (s < 4) ? 2'(3 - s) : 2'(7 - s);
      if (bus.vram_sel !== exp_sel) sel_err++;
      tick();
    end
    total++; if (mc[0] !== 33 || mc[2] !== 33) begin bad++; $display("FAIL m0_map13 got=%0d/%0d exp=33/33", mc[0], mc[2]); end
    total++; if (dc[0] !== 33 || dc[2] !== 33) begin bad++; $display("FAIL m0_dat13 got=%0d/%0d exp=33/33", dc[0], dc[2]); end
    total++; if (mc[1] + mc[3] + dc[1] + dc[3] !== 0)
      begin bad++; $display("FAIL m0_masked got=%0d exp=0", mc[1] + mc[3] + dc[1] + dc[3]); end
    total++; if (sel_err !== 0) begin bad++; $display("FAIL m0_sel got=%0d errs exp=0", sel_err); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL m0_done got=%b exp=0", bus.busy); end
  endtask

  task automatic test_dot_en();
    int en_dots;
    int hold_err;
    logic [8:0] px;
    logic pn;
    logic en;
    en_dots  = 0;
    hold_err = 0;
    start_line(3'd2, 4'hF);
    for (int c = 0; c < 4000; c++) begin
      en = (c % 4 == 3);
      bus.dot_en = en;
      px = bus.fetch_x;
      pn = bus.newline;
      tick();
      if (en) en_dots++;
      else if (bus.fetch_x !== px || bus.newline !== pn) hold_err++;
      if (!bus.busy) break;
    end
    bus.dot_en = 1'b1;
    total++; if (hold_err !== 0) begin bad++; $display("FAIL de_hold got=%0d exp=0", hold_err); end
    total++; if (en_dots !== 264) begin bad++; $display("FAIL de_dots got=%0d exp=264", en_dots); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL de_timeout got=%b exp=0", bus.busy); end
  endtask

  task automatic test_restart();
    start_line(3'd1, 4'hF);
    repeat (100) tick();
    total++; if (bus.fetch_x !== 9'd100) begin bad++; $display("FAIL rs_x100 got=%0d exp=100", bus.fetch_x); end
    bus.bgmode = 3'd5;
    tick();
    total++; if (bus.bg_type !== 12'hE52) begin bad++; $display("FAIL rs_latch got=%h exp=e52", bus.bg_type); end
    start_line(3'd3, 4'hF);
    total++; if (bus.fetch_x !== 9'd0 || bus.newline !== 1'b1)
      begin bad++; $display("FAIL rs_x0 got=%0d/%b exp=0/1", bus.fetch_x, bus.newline); end
    total++; if (bus.bg_type !== 12'hFD3) begin bad++; $display("FAIL rs_type got=%h exp=fd3", bus.bg_type); end
    total++; if (bus.fetch_map !== 4'b0010 || bus.vram_sel !== 2'd1)
      begin bad++; $display("FAIL rs_slot0 got=%b/%0d exp=0010/1", bus.fetch_map, bus.vram_sel); end
  endtask

  task automatic test_inactive();
    bus.line_active = 1'b0;
    bus.line_start  = 1'b1;
    tick();
    bus.line_start  = 1'b0;
    repeat (3) tick();
    total++; if (bus.busy !== 1'b0 || bus.fetch_map !== 4'd0 || bus.fetch_data !== 4'd0)
      begin bad++; $display("FAIL ia_idle got=%b/%b/%b exp=0/0/0", bus.busy, bus.fetch_map, bus.fetch_data); end
  endtask

  task automatic test_mode6();
    logic [3:0]  e_map0, e_map1;
    logic [1:0]  e_sel0;
    logic [2:0]  e_num1;
    logic [11:0] e_type;
`ifdef PPU_BG_OPT_EN
    e_map0 = 4'b0100; e_map1 = 4'b0100; e_sel0 = 2'd2; e_num1 = 3'd1; e_type = 12'hE3E;
`else
    e_map0 = 4'b0000; e_map1 = 4'b0000; e_sel0 = 2'd0; e_num1 = 3'd0; e_type = 12'hFFE;
`endif
    start_line(3'd6, 4'hF);
    total++; if (bus.fetch_map !== e_map0 || bus.vram_sel !== e_sel0)
      begin bad++; $display("FAIL m6_slot0 got=%b/%0d exp=%b/%0d", bus.fetch_map, bus.vram_sel, e_map0, e_sel0); end
    total++; if (bus.bg_type !== e_type) begin bad++; $display("FAIL m6_type got=%h exp=%h", bus.bg_type, e_type); end
    tick();
    total++; if (bus.fetch_map !== e_map1 || bus.fetch_data_num !== e_num1)
      begin bad++; $display("FAIL m6_slot1 got=%b/%0d exp=%b/%0d", bus.fetch_map, bus.fetch_data_num, e_map1, e_num1); end
    tick();
    total++; if ({bus.fetch_map, bus.fetch_data, bus.fetch_data_num} !== 11'd0)
      begin bad++; $display("FAIL m6_slot2 got=%h exp=0", {bus.fetch_map, bus.fetch_data, bus.fetch_data_num}); end
    tick();
    total++; if (bus.fetch_map !== 4'b0001 || bus.vram_sel !== 2'd0)
      begin bad++; $display("FAIL m6_slot3 got=%b/%0d exp=0001/0", bus.fetch_map, bus.vram_sel); end
    repeat (2) tick();
    total++; if (bus.fetch_data !== 4'b0001 || bus.fetch_data_num !== 3'd1)
      begin bad++; $display("FAIL m6_slot5 got=%b/%0d exp=0001/1", bus.fetch_data, bus.fetch_data_num); end
  endtask

  task automatic test_mode7();
    int hits;
    hits = 0;
    start_line(3'd7, 4'hF);
    for (int d = 0; d < 16; d++) begin
      if (bus.fetch_map !== 4'd0 || bus.fetch_data !== 4'd0) hits++;
      tick();
    end
    total++; if (hits !== 0) begin bad++; $display("FAIL m7_silent got=%0d exp=0", hits); end
    total++; if (bus.bg_type !== 12'hFFF || bus.busy !== 1'b1)
      begin bad++; $display("FAIL m7_type got=%h/%b exp=fff/1", bus.bg_type, bus.busy); end
  endtask

  task automatic test_reset_mid();
    logic [11:0] e_type;
`ifdef PPU_BG_OPT_EN
    e_type = 12'hF0B;
`else
    e_type = 12'hFCB;
`endif
    start_line(3'd4, 4'hF);
    repeat (50) tick();
    total++; if (bus.fetch_data !== 4'b0010 || bus.vram_sel !== 2'd1)
      begin bad++; $display("FAIL m4_slot2 got=%b/%0d exp=0010/1", bus.fetch_data, bus.vram_sel); end
    total++; if (bus.bg_type !== e_type) begin bad++; $display("FAIL m4_type got=%h exp=%h", bus.bg_type, e_type); end
    #1;
    reset = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.fetch_x !== 9'd0 || bus.bg_type !== 12'hFFF)
      begin bad++; $display("FAIL ar_now got=%b/%0d/%h exp=0/0/fff", bus.busy, bus.fetch_x, bus.bg_type); end
    total++; if ({bus.fetch_map, bus.fetch_data, bus.fetch_data_num, bus.vram_sel, bus.newline} !== 14'd0)
      begin bad++; $display("FAIL ar_outs got=%h exp=0", {bus.fetch_map, bus.fetch_data, bus.fetch_data_num, bus.vram_sel, bus.newline}); end
    tick();
    reset = 1'b0;
    repeat (5) tick();
    total++; if (bus.busy !== 1'b0 || bus.fetch_x !== 9'd0)
      begin bad++; $display("FAIL ar_idle got=%b/%0d exp=0/0", bus.busy, bus.fetch_x); end
    start_line(3'd0, 4'hF);
    total++; if (bus.busy !== 1'b1 || bus.fetch_map !== 4'b1000)
      begin bad++; $display("FAIL ar_restart got=%b/%b exp=1/1000", bus.busy, bus.fetch_map); end
  endtask

  initial begin
    test_reset();
    test_mode1();
    test_enable_mask();
    test_dot_en();
    test_restart();
    test_inactive();
    test_mode6();
    test_mode7();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
